// File: rtl/data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl
//   Bridges the core's single-cycle data-memory request stage to a wait-stated
//   data bus. A load/store is captured in the request cycle, byte lanes are
//   steered onto the word-wide bus, and the core is stalled until the bus
//   handshake finishes. Load data comes back right-justified to lane 0,
//   zero-filled above the access width, so the upstream extension logic is
//   unchanged.
//
//   Optional feature: define DMC_TIMEOUT_EN to abandon a bus access after
//   TIMEOUT_CYCLES cycles in REQ/WAIT_RSP and report it as an error.
//
// Ports
//   clk, reset      core clock, asynchronous active-high reset
//   req_i           core data request (held while stall_o is high)
//   addr_i          byte address
//   byte_en_i       access size: 2'b00 BYTE, 2'b01 HALF_WORD, 2'b10 WORD
//   wr_i            1 = store, 0 = load
//   wr_data_i       store data, right-justified
//   stall_o         hold core PC/pipeline
//   rd_data_o       load data, right-justified, unextended (held)
//   rd_valid_o      one-cycle pulse: load data valid
//   err_o           one-cycle pulse: illegal access (or timeout)
//   bus_req_o       bus request (REQ state only)
//   bus_addr_o      word-aligned address
//   bus_wr_o        bus write
//   bus_strb_o      byte strobes
//   bus_wdata_o     lane-steered write data
//   bus_gnt_i       bus accepted request
//   bus_rvalid_i    read response valid
//   bus_rdata_i     read response data
// -----------------------------------------------------------------------------
module data_mem_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  input  logic [1:0]  byte_en_i,
  input  logic        wr_i,
  input  logic [31:0] wr_data_i,
  output logic        stall_o,
  output logic [31:0] rd_data_o,
  output logic        rd_valid_o,
  output logic        err_o,
  output logic        bus_req_o,
  output logic [31:0] bus_addr_o,
  output logic        bus_wr_o,
  output logic [3:0]  bus_strb_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i
);

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t      state_reg, state_next;

  logic [31:0] addr_reg;
  logic [1:0]  size_reg;
  logic        wr_reg;
  logic [3:0]  strb_reg;
  logic [31:0] wdata_reg;
  logic        err_reg;
  logic        rd_ok_reg;
  logic [31:0] rd_data_reg;

  logic        legal;
  logic [3:0]  strb_steer;
  logic [31:0] wdata_steer;
  logic [31:0] rdata_shift;
  logic [31:0] rdata_align;
  logic        load_en;
  logic        rsp_en;
  logic        tmo_en;
  logic        tmo_hit;

  // Unencoded sizes and misaligned halfwords/words never reach the bus.
  assign legal = (byte_en_i == SIZE_BYTE) ||
                 ((byte_en_i == SIZE_HALF) && !addr_i[0]) ||
                 ((byte_en_i == SIZE_WORD) && (addr_i[1:0] == 2'b00));

  // Read data is first shifted down by the byte offset, then lanes above the
  // access width are forced to zero.
  assign rdata_shift = bus_rdata_i >> {addr_reg[1:0], 3'b000};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      // Byte data is replicated on every lane, halfword data on each half,
      // so the strobes alone select the destination bytes.
      assign strb_steer[gi] = (byte_en_i == SIZE_BYTE) ? (addr_i[1:0] == 2'(gi)) :
                              (byte_en_i == SIZE_HALF) ? (addr_i[1] == 1'(gi / 2)) :
                              1'b1;
      assign wdata_steer[8*gi +: 8] = (byte_en_i == SIZE_BYTE) ? wr_data_i[7:0] :
                                      (byte_en_i == SIZE_HALF) ? wr_data_i[8*(gi % 2) +: 8] :
                                      wr_data_i[8*gi +: 8];
      assign rdata_align[8*gi +: 8] =
        (((size_reg == SIZE_BYTE) && (gi > 0)) || ((size_reg == SIZE_HALF) && (gi > 1))) ?
        8'h00 : rdata_shift[8*gi +: 8];
    end
  endgenerate

`ifdef DMC_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] tmo_cnt_reg;

  // Counts cycles spent in REQ/WAIT_RSP; restarted by every new capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt_reg <= '0;
    end else if (load_en) begin
      tmo_cnt_reg <= '0;
    end else if ((state_reg == REQ) || (state_reg == WAIT_RSP)) begin
      tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
    end
  end

  // Fires on the last permitted bus cycle, so bus_req_o is high for exactly
  // TIMEOUT_CYCLES cycles before the access is abandoned.
  assign tmo_hit = ((32'(tmo_cnt_reg) + 32'd1) >= TIMEOUT_CYCLES);
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    stall_o    = 1'b0;
    bus_req_o  = 1'b0;
    rd_valid_o = 1'b0;
    err_o      = 1'b0;
    load_en    = 1'b0;
    rsp_en     = 1'b0;
    tmo_en     = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (req_i) begin
          stall_o    = 1'b1;
          load_en    = 1'b1;
          state_next = legal ? REQ : DONE;
        end
      end
      REQ: begin
        stall_o   = 1'b1;
        bus_req_o = 1'b1;
        if (bus_gnt_i) begin
          if (wr_reg) begin
            state_next = DONE;
          end else if (bus_rvalid_i) begin
            rsp_en     = 1'b1;
            state_next = DONE;
          end else begin
            state_next = WAIT_RSP;
          end
        end else if (tmo_hit) begin
          tmo_en     = 1'b1;
          state_next = DONE;
        end
      end
      WAIT_RSP: begin
        stall_o = 1'b1;
        if (bus_rvalid_i) begin
          rsp_en     = 1'b1;
          state_next = DONE;
        end else if (tmo_hit) begin
          tmo_en     = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        rd_valid_o = rd_ok_reg;
        err_o      = err_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_reg    <= '0;
      size_reg    <= '0;
      wr_reg      <= 1'b0;
      strb_reg    <= '0;
      wdata_reg   <= '0;
      err_reg     <= 1'b0;
      rd_ok_reg   <= 1'b0;
      rd_data_reg <= '0;
    end else begin
      if (load_en) begin
        addr_reg  <= addr_i;
        size_reg  <= byte_en_i;
        wr_reg    <= wr_i;
        strb_reg  <= strb_steer;
        wdata_reg <= wdata_steer;
        err_reg   <= ~legal;
        rd_ok_reg <= legal & ~wr_i;
        if (!legal) begin
          rd_data_reg <= '0;
        end
      end
      if (rsp_en) begin
        rd_data_reg <= rdata_align;
      end
      if (tmo_en) begin
        err_reg     <= 1'b1;
        rd_ok_reg   <= 1'b0;
        rd_data_reg <= '0;
      end
    end
  end

  assign bus_addr_o  = {addr_reg[31:2], 2'b00};
  assign bus_wr_o    = wr_reg;
  assign bus_strb_o  = strb_reg;
  assign bus_wdata_o = wdata_reg;
  assign rd_data_o   = rd_data_reg;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_data_mem_ctrl
//   Table of directed accesses with constant expectations, randomized accesses
//   checked against a byte-level reference model, and hand-written sequences
//   for reset mid-transaction and the bus-wait limit.
// -----------------------------------------------------------------------------
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_i;
  logic [31:0] addr_i;
  logic [1:0]  byte_en_i;
  logic        wr_i;
  logic [31:0] wr_data_i;
  logic        stall_o;
  logic [31:0] rd_data_o;
  logic        rd_valid_o;
  logic        err_o;
  logic        bus_req_o;
  logic [31:0] bus_addr_o;
  logic        bus_wr_o;
  logic [3:0]  bus_strb_o;
  logic [31:0] bus_wdata_o;
  logic        bus_gnt_i;
  logic        bus_rvalid_i;
  logic [31:0] bus_rdata_i;

  always #5 clk = ~clk;

  data_mem_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_i        (req_i),
    .addr_i       (addr_i),
    .byte_en_i    (byte_en_i),
    .wr_i         (wr_i),
    .wr_data_i    (wr_data_i),
    .stall_o      (stall_o),
    .rd_data_o    (rd_data_o),
    .rd_valid_o   (rd_valid_o),
    .err_o        (err_o),
    .bus_req_o    (bus_req_o),
    .bus_addr_o   (bus_addr_o),
    .bus_wr_o     (bus_wr_o),
    .bus_strb_o   (bus_strb_o),
    .bus_wdata_o  (bus_wdata_o),
    .bus_gnt_i    (bus_gnt_i),
    .bus_rvalid_i (bus_rvalid_i),
    .bus_rdata_i  (bus_rdata_i)
  );

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  be;
    logic        wr;
    logic [31:0] wdata;
    int          gdly;
    int          rdly;
    logic [31:0] rdata;
    logic [31:0] exp_baddr;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
    logic        exp_err;
    logic        exp_rv;
    logic [31:0] exp_rd;
    int          exp_lat;
    int          exp_req;
  } vec_t;

  typedef struct {
    int          done;
    int          lat;
    int          req_cycles;
    int          err_cnt;
    int          rv_cnt;
    int          unstable;
    int          post_bad;
    logic [31:0] rd;
    logic [31:0] post_rd;
    logic [31:0] baddr;
    logic [31:0] bwdata;
    logic [3:0]  strb;
    logic        bwr;
  } res_t;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] model_rd = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic [31:0] a, input logic [1:0] be, input logic w,
                               input logic [31:0] wd, input int g, input int rdl,
                               input logic [31:0] rdat, input logic [31:0] eba,
                               input logic [3:0] es, input logic [31:0] ewd, input logic ee,
                               input logic erv, input logic [31:0] erd, input int elat,
                               input int ereq);
    vec_t v;
    v.addr = a; v.be = be; v.wr = w; v.wdata = wd; v.gdly = g; v.rdly = rdl; v.rdata = rdat;
    v.exp_baddr = eba; v.exp_strb = es; v.exp_wdata = ewd; v.exp_err = ee; v.exp_rv = erv;
    v.exp_rd = erd; v.exp_lat = elat; v.exp_req = ereq;
    return v;
  endfunction

  // Reference model: an access covers bytes [addr%4, addr%4+nbytes) of the
  // word; store data is the access-sized value repeated across the word.
  function automatic vec_t model(input logic [31:0] a, input logic [1:0] be, input logic w,
                                 input logic [31:0] wd, input int g, input int rdl,
                                 input logic [31:0] rdat, input logic [31:0] prev_rd);
    vec_t        v;
    int          nb;
    int          off;
    logic [63:0] wide;
    v.addr = a; v.be = be; v.wr = w; v.wdata = wd; v.gdly = g; v.rdly = rdl; v.rdata = rdat;
    nb  = (be == 2'd0) ? 1 : (be == 2'd1) ? 2 : (be == 2'd2) ? 4 : 0;
    off = int'(a % 4);
    v.exp_err   = (nb == 0) || ((off % ((nb == 0) ? 1 : nb)) != 0);
    v.exp_baddr = a - (a % 4);
    v.exp_strb  = '0;
    v.exp_wdata = '0;
    if (!v.exp_err) begin
      for (int i = 0; i < 4; i++) begin
        v.exp_strb[i] = (i >= off) && (i < off + nb);
        v.exp_wdata[8*i +: 8] = wd[8*(i % nb) +: 8];
      end
    end
    wide = {32'h0, rdat} >> (8 * off);
    if (nb > 0) wide = wide & ((64'h1 << (8 * nb)) - 64'h1);
    v.exp_rd  = v.exp_err ? 32'h0 : (w ? prev_rd : wide[31:0]);
    v.exp_rv  = !v.exp_err && !w;
    v.exp_lat = v.exp_err ? 1 : (2 + g + (w ? 0 : rdl));
    v.exp_req = v.exp_err ? 0 : (g + 1);
    return v;
  endfunction

  // Issues one request and plays a bus that grants after gdly request cycles
  // and answers a read rdly cycles after the grant. Inputs are driven 1 time
  // unit after the rising edge; outputs are sampled on the falling edge.
  task automatic run_access(input vec_t v, input int maxc, output res_t r);
    int req_cnt;
    int rsp_at;
    r.done = 0; r.lat = -1; r.req_cycles = 0; r.err_cnt = 0; r.rv_cnt = 0;
    r.unstable = 0; r.post_bad = 0; r.rd = '0; r.post_rd = '0; r.baddr = '0;
    r.bwdata = '0; r.strb = '0; r.bwr = 1'b0;
    req_cnt = 0;
    rsp_at  = -1;
    for (int c = 0; c < maxc; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) begin
        req_i = 1'b1; addr_i = v.addr; byte_en_i = v.be; wr_i = v.wr; wr_data_i = v.wdata;
      end
      bus_gnt_i    = 1'b0;
      bus_rvalid_i = 1'b0;
      bus_rdata_i  = $urandom;
      if (bus_req_o) begin
        if (req_cnt == v.gdly) begin
          bus_gnt_i = 1'b1;
          if (!v.wr) rsp_at = c + v.rdly;
        end
        req_cnt++;
      end
      if (c == rsp_at) begin
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = v.rdata;
      end
      @(negedge clk);
      if (bus_req_o) begin
        if (r.req_cycles == 0) begin
          r.baddr = bus_addr_o; r.strb = bus_strb_o; r.bwdata = bus_wdata_o; r.bwr = bus_wr_o;
        end else if (bus_addr_o !== r.baddr || bus_strb_o !== r.strb ||
                     bus_wdata_o !== r.bwdata || bus_wr_o !== r.bwr) begin
          r.unstable++;
        end
        r.req_cycles++;
      end
      if (rd_valid_o) r.rv_cnt++;
      if (err_o) r.err_cnt++;
      if (stall_o !== 1'b1) begin
        r.done = 1;
        r.lat  = c;
        r.rd   = rd_data_o;
        break;
      end
    end
    req_i        = 1'b0;
    bus_gnt_i    = 1'b0;
    bus_rvalid_i = 1'b0;
    if (r.done != 0) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      r.post_rd  = rd_data_o;
      r.post_bad = int'(rd_valid_o | err_o | bus_req_o | stall_o);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    res_t r;
    run_access(v, 40, r);
    check({tag, ".latency"},    r.lat,        v.exp_lat);
    check({tag, ".req_cycles"}, r.req_cycles, v.exp_req);
    check({tag, ".err_pulse"},  r.err_cnt,    {31'h0, v.exp_err});
    check({tag, ".rv_pulse"},   r.rv_cnt,     {31'h0, v.exp_rv});
    check({tag, ".rd_data"},    r.rd,         v.exp_rd);
    check({tag, ".rd_hold"},    r.post_rd,    v.exp_rd);
    check({tag, ".post_idle"},  r.post_bad,   0);
    if (v.exp_req > 0) begin
      check({tag, ".bus_addr"},  r.baddr,    v.exp_baddr);
      check({tag, ".bus_strb"},  r.strb,     v.exp_strb);
      check({tag, ".bus_wdata"}, r.bwdata,   v.exp_wdata);
      check({tag, ".bus_wr"},    r.bwr,      v.wr);
      check({tag, ".stable"},    r.unstable, 0);
    end
    model_rd = v.exp_rd;
    $display("txn %s addr=%h be=%0d wr=%0b lat=%0d rd=%h err=%0d rv=%0d",
             tag, v.addr, v.be, v.wr, r.lat, r.rd, r.err_cnt, r.rv_cnt);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    req_i = 1'b0; bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    model_rd = '0;
  endtask

  vec_t tbl[10];

  initial begin
    vec_t v;
    res_t r;
    int   acc;

    reset = 1'b1; req_i = 1'b0; addr_i = '0; byte_en_i = '0; wr_i = 1'b0; wr_data_i = '0;
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0;

    //            addr          be    wr    wdata         g  r  rdata         baddr         strb   wdata_exp     err   rv    rd            lat req
    tbl[0] = mkv(32'h0000_1003, 2'd0, 1'b1, 32'h0000_00A5, 2, 0, 32'h0,        32'h0000_1000, 4'h8, 32'hA5A5_A5A5, 1'b0, 1'b0, 32'h0,        4, 3);
    tbl[1] = mkv(32'h0000_2002, 2'd1, 1'b0, 32'h0,        0, 3, 32'hBEEF_1234, 32'h0000_2000, 4'hC, 32'h0,        1'b0, 1'b1, 32'h0000_BEEF, 5, 1);
    tbl[2] = mkv(32'h0000_0010, 2'd2, 1'b0, 32'h0,        0, 0, 32'hDEAD_BEEF, 32'h0000_0010, 4'hF, 32'h0,        1'b0, 1'b1, 32'hDEAD_BEEF, 2, 1);
    tbl[3] = mkv(32'h0000_0006, 2'd2, 1'b0, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 32'h0,        1'b1, 1'b0, 32'h0,        1, 0);
    tbl[4] = mkv(32'h0000_0031, 2'd0, 1'b0, 32'h0,        1, 1, 32'h1122_3344, 32'h0000_0030, 4'h2, 32'h0,        1'b0, 1'b1, 32'h0000_0033, 4, 2);
    tbl[5] = mkv(32'h0000_0005, 2'd1, 1'b0, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 32'h0,        1'b1, 1'b0, 32'h0,        1, 0);
    tbl[6] = mkv(32'h0000_000A, 2'd1, 1'b1, 32'hFFFF_8001, 0, 0, 32'h0,        32'h0000_0008, 4'hC, 32'h8001_8001, 1'b0, 1'b0, 32'h0,        2, 1);
    tbl[7] = mkv(32'h0000_0020, 2'd3, 1'b1, 32'h1234_5678, 0, 0, 32'h0,        32'h0,        4'h0, 32'h0,        1'b1, 1'b0, 32'h0,        1, 0);
    tbl[8] = mkv(32'h0000_2000, 2'd0, 1'b0, 32'h0,        0, 2, 32'hCAFE_F00D, 32'h0000_2000, 4'h1, 32'h0,        1'b0, 1'b1, 32'h0000_000D, 4, 1);
    tbl[9] = mkv(32'h0000_0044, 2'd2, 1'b1, 32'h0123_4567, 1, 0, 32'h0,        32'h0000_0044, 4'hF, 32'h0123_4567, 1'b0, 1'b0, 32'h0000_000D, 3, 2);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.stall",      stall_o,     0);
    check("reset.rd_data",    rd_data_o,   0);
    check("reset.rd_valid",   rd_valid_o,  0);
    check("reset.err",        err_o,       0);
    check("reset.bus_req",    bus_req_o,   0);
    check("reset.bus_addr",   bus_addr_o,  0);
    check("reset.bus_wr",     bus_wr_o,    0);
    check("reset.bus_strb",   bus_strb_o,  0);
    check("reset.bus_wdata",  bus_wdata_o, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Directed table
    for (int i = 0; i < 10; i++) begin
      apply(tbl[i], $sformatf("tbl%0d", i));
    end

    // Randomized accesses against the model
    for (int n = 0; n < 40; n++) begin
      v = model($urandom & 32'h0000_FFFF, 2'($urandom_range(3, 0)), 1'($urandom_range(1, 0)),
                $urandom, $urandom_range(2, 0), $urandom_range(1, 0), $urandom, model_rd);
      apply(v, $sformatf("rnd%0d", n));
    end

    // Reset while the request is on the bus: bus_req_o must fall without a clock
    @(posedge clk);
    #1;
    req_i = 1'b1; addr_i = 32'h40; byte_en_i = 2'd2; wr_i = 1'b0; bus_gnt_i = 1'b0;
    @(posedge clk);
    #1;
    req_i = 1'b0;
    @(negedge clk);
    check("rst_req.bus_req_before", bus_req_o, 1);
    #1;
    reset = 1'b1;
    #1;
    check("rst_req.bus_req_async", bus_req_o, 0);
    check("rst_req.stall",         stall_o,   0);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    model_rd = '0;

    // Reset in WAIT_RSP, then the stale response arrives
    @(posedge clk);
    #1;
    req_i = 1'b1; addr_i = 32'h84; byte_en_i = 2'd2; wr_i = 1'b0;
    @(posedge clk);
    #1;
    req_i = 1'b0; bus_gnt_i = 1'b1;
    @(posedge clk);
    #1;
    bus_gnt_i = 1'b0;
    @(negedge clk);
    check("rst_wait.stall_before",   stall_o,   1);
    check("rst_wait.bus_req_before", bus_req_o, 0);
    #1;
    reset = 1'b1;
    #1;
    check("rst_wait.stall", stall_o, 0);
    @(posedge clk);
    #1;
    reset = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = 32'h1234_5678;
    acc = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      acc += int'(rd_valid_o | err_o | stall_o | bus_req_o);
      @(posedge clk);
      #1;
      bus_rvalid_i = 1'b0;
    end
    check("rst_wait.late_rvalid_ignored", acc, 0);
    check("rst_wait.rd_data", rd_data_o, 0);
    $display("txn rst_wait addr=00000084 activity=%0d rd=%h", acc, rd_data_o);

    // A nonzero load so the next case shows rd_data_o being cleared
    apply(mkv(32'h0000_0100, 2'd2, 1'b0, 32'h0, 0, 0, 32'h5555_AAAA, 32'h0000_0100, 4'hF,
              32'h0, 1'b0, 1'b1, 32'h5555_AAAA, 2, 1), "pre_wait");

`ifdef DMC_TIMEOUT_EN
    // Grant never comes: four REQ cycles, then an error pulse
    apply(mkv(32'h0000_0080, 2'd2, 1'b0, 32'h0, 1000, 0, 32'h0, 32'h0000_0080, 4'hF,
              32'h0, 1'b1, 1'b0, 32'h0, 5, 4), "timeout");
    @(posedge clk);
    #1;
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'hFFFF_FFFF;
    @(negedge clk);
    acc = int'(rd_valid_o | err_o | stall_o);
    @(posedge clk);
    #1;
    bus_rvalid_i = 1'b0;
    @(negedge clk);
    acc += int'(rd_valid_o | err_o | stall_o);
    check("timeout.late_rvalid_ignored", acc, 0);
    check("timeout.rd_data", rd_data_o, 0);
`else
    // Grant never comes: the core stays stalled for as long as we watch
    v = mkv(32'h0000_0080, 2'd2, 1'b0, 32'h0, 1000, 0, 32'h0, 32'h0000_0080, 4'hF,
            32'h0, 1'b0, 1'b1, 32'h0, 0, 0);
    run_access(v, 30, r);
    check("no_timeout.done",       r.done,       0);
    check("no_timeout.req_cycles", r.req_cycles, 29);
    check("no_timeout.err_pulse",  r.err_cnt,    0);
    check("no_timeout.stall_now",  stall_o,      1);
    $display("txn no_timeout addr=00000080 req_cycles=%0d done=%0d", r.req_cycles, r.done);
    do_reset();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
